// File: rtl/tmr_counter_channel_if.sv
// CPU register bus of one 8-bit timer channel.
//   cpu_wr_en / cpu_rd_en : write / read strobes, at most one high per cycle
//   cpu_addr              : 0=TCNT, 1=TCORA, 2=TCORB, 3=TCSR
//   cpu_wdata             : write data
//   cpu_rdata             : registered read data, holds until the next read
// master = CPU side, slave = timer channel.
interface tmr_counter_channel_if #(
  parameter int unsigned BIT_WIDTH = 8
);
  logic                 cpu_wr_en;
  logic                 cpu_rd_en;
  logic [1:0]           cpu_addr;
  logic [BIT_WIDTH-1:0] cpu_wdata;
  logic [BIT_WIDTH-1:0] cpu_rdata;

  modport master (
    output cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wdata,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wdata,
    output cpu_rdata
  );
endinterface

// File: rtl/tmr_counter_channel.sv
// One channel of the 8-bit timer: clock-select decode, 13-bit prescaler,
// TCNT up-counter, TCORA/TCORB constant registers, compare-match and
// overflow detection, and TCSR with sticky, read-armed flags.
//
// Ports:
//   clk, rst       : system clock; asynchronous active-high reset
//   clock_select   : [4:2]=CKS2..0, [1:0]=ICKS1..0 (ICKS1 ignored)
//   counter_clear  : clear TCNT at the next edge (below a CPU TCNT write)
//   tmci           : external clock pin, asynchronous
//   cascade_tick   : one-cycle count pulse from the other channel
//   bus            : CPU register bus (slave side)
//   TCNT, TCSR     : counter value, {CMFB, CMFA, OVF, ADTE, OS3..OS0}
//   CompareMatchA/B, Overflow : registered one-cycle event pulses
//
// Build option: define TMR_CASCADE_EN to let CKS=100 count cascade_tick;
// otherwise CKS=100 is stopped and cascade_tick is ignored.
module tmr_counter_channel #(
  parameter int unsigned BIT_WIDTH            = 8,
  parameter int unsigned CLK_SELECT_BIT_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select,
  input  logic                            counter_clear,
  input  logic                            tmci,
  input  logic                            cascade_tick,
  tmr_counter_channel_if.slave            bus,
  output logic [BIT_WIDTH-1:0]            TCNT,
  output logic [BIT_WIDTH-1:0]            TCSR,
  output logic                            CompareMatchA,
  output logic                            CompareMatchB,
  output logic                            Overflow
);

  localparam int unsigned PRESC_W = 13;
  localparam int unsigned CTRL_W  = 5;
  localparam int unsigned FLAG_W  = 3;

  localparam logic [1:0] ADDR_TCNT  = 2'd0;
  localparam logic [1:0] ADDR_TCORA = 2'd1;
  localparam logic [1:0] ADDR_TCORB = 2'd2;
  localparam logic [1:0] ADDR_TCSR  = 2'd3;

  logic [PRESC_W-1:0]   presc;
  logic                 tmci_meta, tmci_sync, tmci_prev;
  logic                 tmci_rise, tmci_fall;
  logic                 div2, div8, div32, div64, div1024, div8192;
  logic [2:0]           cks;
  logic                 icks0;
  logic                 count_tick;
  logic                 count_inc;
  logic [BIT_WIDTH-1:0] tcnt_plus1;
  logic [BIT_WIDTH-1:0] tcora, tcorb;
  logic                 tcnt_wr, tcora_wr, tcorb_wr, tcsr_wr, tcsr_rd;
  logic [FLAG_W-1:0]    flags;       // {CMFB, CMFA, OVF}
  logic [FLAG_W-1:0]    armed;
  logic [FLAG_W-1:0]    flag_set, flag_clr, flags_next, armed_next;
  logic [CTRL_W-1:0]    ctrl;        // {ADTE, OS3..OS0}
  logic                 unused_inputs;

  assign cks   = clock_select[4:2];
  assign icks0 = clock_select[0];

`ifdef TMR_CASCADE_EN
  assign unused_inputs = clock_select[1];
`else
  assign unused_inputs = clock_select[1] ^ cascade_tick;
`endif

  // Free-running prescaler; reset restarts the divider phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= presc + PRESC_W'(1);
  end

  // Divide-by-2^k tick: low k prescaler bits all ones.
  assign div2    = presc[0];
  assign div8    = &presc[2:0];
  assign div32   = &presc[4:0];
  assign div64   = &presc[5:0];
  assign div1024 = &presc[9:0];
  assign div8192 = &presc[12:0];

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmci_meta <= 1'b0;
      tmci_sync <= 1'b0;
      tmci_prev <= 1'b0;
    end else begin
      tmci_meta <= tmci;
      tmci_sync <= tmci_meta;
      tmci_prev <= tmci_sync;
    end
  end

  assign tmci_rise = tmci_sync & ~tmci_prev;
  assign tmci_fall = ~tmci_sync & tmci_prev;

  // Count source selection.
  always_comb begin
    count_tick = 1'b0;
    case (cks)
      3'b000:  count_tick = 1'b0;
      3'b001:  count_tick = icks0 ? div2    : div8;
      3'b010:  count_tick = icks0 ? div32   : div64;
      3'b011:  count_tick = icks0 ? div1024 : div8192;
      3'b100: begin
`ifdef TMR_CASCADE_EN
        count_tick = cascade_tick;
`else
        count_tick = 1'b0;
`endif
      end
      3'b101:  count_tick = tmci_rise;
      3'b110:  count_tick = tmci_fall;
      default: count_tick = tmci_rise | tmci_fall;
    endcase
  end

  assign tcnt_wr  = bus.cpu_wr_en && (bus.cpu_addr == ADDR_TCNT);
  assign tcora_wr = bus.cpu_wr_en && (bus.cpu_addr == ADDR_TCORA);
  assign tcorb_wr = bus.cpu_wr_en && (bus.cpu_addr == ADDR_TCORB);
  assign tcsr_wr  = bus.cpu_wr_en && (bus.cpu_addr == ADDR_TCSR);
  assign tcsr_rd  = bus.cpu_rd_en && (bus.cpu_addr == ADDR_TCSR);

  // Only a genuine increment (not a write or clear) can produce events.
  assign count_inc  = count_tick && !tcnt_wr && !counter_clear;
  assign tcnt_plus1 = TCNT + BIT_WIDTH'(1);

  // Counter, constant registers and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TCNT          <= '0;
      tcora         <= '1;
      tcorb         <= '1;
      CompareMatchA <= 1'b0;
      CompareMatchB <= 1'b0;
      Overflow      <= 1'b0;
    end else begin
      if (tcnt_wr)            TCNT <= bus.cpu_wdata;
      else if (counter_clear) TCNT <= '0;
      else if (count_tick)    TCNT <= tcnt_plus1;

      if (tcora_wr) tcora <= bus.cpu_wdata;
      if (tcorb_wr) tcorb <= bus.cpu_wdata;

      CompareMatchA <= count_inc && (tcnt_plus1 == tcora);
      CompareMatchB <= count_inc && (tcnt_plus1 == tcorb);
      Overflow      <= count_inc && (TCNT == '1);
    end
  end

  // Flag update: a set beats a coincident clear; a clear needs a prior
  // read that saw the flag at 1, and any TCSR write disarms all flags.
  always_comb begin
    flag_set   = {CompareMatchB, CompareMatchA, Overflow};
    flag_clr   = {FLAG_W{tcsr_wr}} & ~bus.cpu_wdata[BIT_WIDTH-1 -: FLAG_W] & armed;
    flags_next = flag_set | (flags & ~flag_clr);
    armed_next = armed;
    if (tcsr_wr)      armed_next = '0;
    else if (tcsr_rd) armed_next = armed | flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
      armed <= '0;
      ctrl  <= '0;
    end else begin
      flags <= flags_next;
      armed <= armed_next;
      if (tcsr_wr) ctrl <= bus.cpu_wdata[CTRL_W-1:0];
    end
  end

  assign TCSR = BIT_WIDTH'({flags, ctrl});

  // Registered read-back, held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cpu_rdata <= '0;
    end else if (bus.cpu_rd_en) begin
      case (bus.cpu_addr)
        ADDR_TCNT:  bus.cpu_rdata <= TCNT;
        ADDR_TCORA: bus.cpu_rdata <= tcora;
        ADDR_TCORB: bus.cpu_rdata <= tcorb;
        default:    bus.cpu_rdata <= TCSR;
      endcase
    end
  end

endmodule
